// File: rtl/imem_boot_controller.sv
// imem_boot_controller
// Owns the single write port of the instruction memory and decides who drives
// its address. After reset it zero-fills every word, then streams a program in
// from the host over a valid/ready handshake, then releases the CPU into run
// mode, where the CPU byte PC is mapped onto word addresses with no latency.
// A reload request in run mode repeats the clear/load sequence.

module imem_boot_controller #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,

    // Host program load stream
    input  logic                host_valid,
    output logic                host_ready,
    input  logic [31:0]         host_data,
    input  logic                host_last,

    // CPU fetch side
    input  logic                reload,
    input  logic [31:0]         pc,
    output logic [31:0]         instruction,
    output logic                cpu_hold,

    // Instruction memory port
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,

    // Load status
    output logic [ADDR_W:0]     load_count,
    output logic                overflow,
    output logic                pc_fault
);

    // Sequencer states
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    // Last word address; reaching it ends the clear sweep or fills the memory
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    // Word count compared against the word index of the CPU PC
    localparam logic [29:0]       DEPTH_WORDS = 30'(DEPTH);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_loadCount;
    logic              r_overflow;

    logic              w_inClear;
    logic              w_inLoad;
    logic              w_inRun;
    logic              w_handshake;
    logic              w_ptrAtLast;
    logic              w_pcMisaligned;
    logic              w_pcOutOfRange;
    logic              w_pcFault;
    logic [ADDR_W-1:0] w_fetchAddr;

    assign w_inClear      = (r_state == S_CLEAR);
    assign w_inLoad       = (r_state == S_LOAD);
    assign w_inRun        = (r_state == S_RUN);
    assign w_ptrAtLast    = (r_ptr == LAST_ADDR);

    // host_ready is constant-high in LOAD, so a handshake is just valid in LOAD
    assign w_handshake    = w_inLoad && host_valid;

    // A fetch is illegal when it is not word aligned or falls past the memory
    assign w_pcMisaligned = (pc[1:0] != 2'b00);
    assign w_pcOutOfRange = (pc[31:2] >= DEPTH_WORDS);
    assign w_pcFault      = w_pcMisaligned || w_pcOutOfRange;
    assign w_fetchAddr    = pc[ADDR_W+1:2];

    // State sequencing: clear sweep -> program load -> run, reload restarts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (w_ptrAtLast) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_handshake && (host_last || w_ptrAtLast)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        r_state <= S_CLEAR;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    // Write pointer shared by the clear sweep and the load stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (w_ptrAtLast) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_handshake) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        r_ptr <= '0;
                    end
                end
                default: begin
                    r_ptr <= '0;
                end
            endcase
        end
    end

    // Load statistics: words accepted and the sticky missing-last indication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loadCount <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_inClear && w_ptrAtLast) begin
                r_loadCount <= '0;
                r_overflow  <= 1'b0;
            end else if (w_handshake) begin
                r_loadCount <= r_loadCount + 1'b1;
                if (!host_last && w_ptrAtLast) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Output steering; everything is forced to its safe value while rst is high
    always_comb begin
        host_ready  = 1'b0;
        cpu_hold    = 1'b1;
        mem_we      = 1'b0;
        mem_addr    = r_ptr;
        mem_wdata   = 32'h0000_0000;
        instruction = 32'h0000_0000;
        pc_fault    = 1'b0;
        if (!rst) begin
            if (w_inClear) begin
                mem_we = 1'b1;
            end else if (w_inLoad) begin
                host_ready = 1'b1;
                mem_we     = host_valid;
                mem_wdata  = host_data;
            end else if (w_inRun) begin
                cpu_hold    = 1'b0;
                mem_addr    = w_fetchAddr;
                pc_fault    = w_pcFault;
                instruction = w_pcFault ? 32'h0000_0000 : mem_rdata;
            end
        end
    end

    assign load_count = r_loadCount;
    assign overflow   = r_overflow;

endmodule
